simplex_resp_xbar: RTL and testbench
====================================

Name: simplex_resp_xbar

Overview:
- Return-path crossbar for the variable-latency interconnect; carries target responses back to the initiators.
- Each of NumOut targets pushes a response tagged with the initiator index it received alongside the request.
- Each target's response is buffered in a per-target FIFO.
- A per-initiator round-robin arbiter with grant lock steers buffered responses to the addressed initiator. Each delivered response carries the source target index.

Parameters:
- NumIn, 4: number of initiators (response destinations).
- NumOut, 4: number of targets (response sources).
- DataWidth, 32: response payload width.
- FifoDepth, 2: entries per target response FIFO. Must be a power of two, at least 1.
- NumInLog, derived: NumIn==1 ? 1 : $clog2(NumIn). Do not override.
- NumOutLog, derived: NumOut==1 ? 1 : $clog2(NumOut). Do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- resp_valid_i  in  NumOut  target response valid.
- resp_ready_o  out  NumOut  target response ready.
- resp_ini_addr_i  in  NumOut x NumInLog  destination initiator index.
- resp_data_i  in  NumOut x DataWidth  response payload.
- resp_valid_o  out  NumIn  initiator response valid.
- resp_ready_i  in  NumIn  initiator response ready.
- resp_tgt_addr_o  out  NumIn x NumOutLog  source target index.
- resp_data_o  out  NumIn x DataWidth  response payload.
- drop_o  out  NumOut  one-cycle pulse: response with out-of-range initiator index discarded.

Behaviour:
- Reset is asynchronous, active-low. It clears:
  - all FIFO pointers and counts (FIFOs empty);
  - all RR pointers to 0;
  - all grant locks.
- Output values during and after reset: resp_valid_o=0, resp_ready_o=all 1s, drop_o=0. Data outputs are don't-care while valid is low.
- Target side:
  - resp_ready_o[k] = FIFO k not full. It depends only on state, with no combinational path from resp_ready_i.
  - A push happens when resp_valid_i[k] && resp_ready_o[k].
  - A full FIFO does not accept a push, even if it pops in the same cycle (no fall-through on full).
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Out-of-range index: if a pushed resp_ini_addr_i[k] >= NumIn (only possible when NumIn is not a power of two):
  - the entry is not stored;
  - drop_o[k] pulses in the next cycle;
  - ready behaves as a normal accept.
- Latency: minimum 1 cycle from target handshake to resp_valid_o. A push into an empty FIFO is visible at the head in the following cycle.
- Request vector: initiator j requests from target k when FIFO k is non-empty and its head index == j. Each FIFO head addresses exactly one initiator.
- Arbitration per initiator j:
  - Round-robin, starting the search at rr_ptr[j] and wrapping modulo NumOut.
  - resp_valid_o[j] = OR of the request vector.
  - resp_data_o[j] and resp_tgt_addr_o[j] come from the granted head.
- Grant lock:
  - If resp_valid_o[j] && !resp_ready_i[j], lock[j] is set and the granted k is held.
  - While locked, valid, data and tgt_addr stay stable until the handshake, even if a higher-priority head appears.
- On handshake (resp_valid_o[j] && resp_ready_i[j]):
  - pop FIFO k;
  - set rr_ptr[j] = (k+1) mod NumOut;
  - clear lock[j].
- rr_ptr updates only on handshake.
- Non-handshake cycles leave the pointer unchanged, so there is no starvation under continuous backpressure.
- Independence: initiators never block one another. A head stalled at initiator j blocks only its own FIFO (head-of-line blocking per target is accepted behaviour).
- Throughput:
  - each target can complete one push per cycle;
  - each initiator can complete one pop per cycle;
  - with FifoDepth>=2, sustained 1 response per cycle per target when uncontended.
- Assertions:
  - $fatal if NumIn==0, NumOut==0, or FifoDepth is not a power of two.
  - Simulation check: a locked output must stay stable until its handshake.

Test Plan:
1. Reset mid-traffic: assert rst_ni low with 2 entries in FIFO 1 -> same cycle resp_valid_o=0 and resp_ready_o=4'b1111. After release, no stale response is delivered.
2. Single path: target 2 pushes data 0xA5A5_0001 with ini_addr 3 at cycle t, resp_ready_i[3]=1 -> resp_valid_o[3]=1 at t+1, resp_tgt_addr_o[3]=2, data matches. FIFO 2 is empty at t+2.
3. RR fairness: targets 0, 1 and 3 continuously send to initiator 0 with ready held high -> grant order 0,1,3,0,1,3. No target is served twice before the others.
4. Lock under backpressure: resp_ready_i[1]=0 with a target 2 head granted, then target 0 (higher priority at rr_ptr=0) gets a head for initiator 1 -> output stays target 2 with the same data until ready rises. Next grant is target 0.
5. Full FIFO: FifoDepth=2, resp_ready_i=0, target 0 pushes 3 times -> resp_ready_o[0]=0 after 2 accepts. A simultaneous pop on full does not accept the pushed beat that cycle. The 3rd beat is accepted one cycle after the pop.
6. Out of range: NumIn=3, push ini_addr=3 on target 1 -> drop_o[1]=1 for exactly one cycle. No resp_valid_o asserts and the FIFO count is unchanged.

Source files
------------

// File: rtl/simplex_resp_xbar.sv
// simplex_resp_xbar: return-path crossbar. Each target pushes a response tagged
// with its destination initiator into its own FIFO. Each initiator runs a
// round-robin arbiter, with a grant lock, over the FIFO heads that address it.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   resp_valid_i/ready_o target-side handshake (ready = FIFO not full, state only)
//   resp_ini_addr_i      destination initiator index per target
//   resp_data_i          response payload per target
//   resp_valid_o/ready_i initiator-side handshake
//   resp_tgt_addr_o      index of the target that sourced the delivered response
//   resp_data_o          delivered payload
//   drop_o               one-cycle pulse: pushed response had an out-of-range index
//
// Handshake rule (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. Once the crossbar raises resp_valid_o it keeps
// valid, tgt_addr and data stable until that transfer takes place.
module simplex_resp_xbar #(
  parameter int unsigned NumIn     = 4,
  parameter int unsigned NumOut    = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned FifoDepth = 2,
  parameter int unsigned NumInLog  = (NumIn == 1) ? 1 : $clog2(NumIn),
  parameter int unsigned NumOutLog = (NumOut == 1) ? 1 : $clog2(NumOut)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumOut-1:0]                   resp_valid_i,
  output logic [NumOut-1:0]                   resp_ready_o,
  input  logic [NumOut-1:0][NumInLog-1:0]     resp_ini_addr_i,
  input  logic [NumOut-1:0][DataWidth-1:0]    resp_data_i,
  output logic [NumIn-1:0]                    resp_valid_o,
  input  logic [NumIn-1:0]                    resp_ready_i,
  output logic [NumIn-1:0][NumOutLog-1:0]     resp_tgt_addr_o,
  output logic [NumIn-1:0][DataWidth-1:0]     resp_data_o,
  output logic [NumOut-1:0]                   drop_o
);

  localparam int unsigned PtrW = (FifoDepth == 1) ? 1 : $clog2(FifoDepth);
  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  // One extra bit so the range check is meaningful for every NumIn.
  localparam logic [NumInLog:0] NumInLimit = (NumInLog + 1)'(NumIn);

  if (NumIn == 0 || NumOut == 0 || FifoDepth == 0 ||
      (FifoDepth & (FifoDepth - 1)) != 0) begin : g_param_fatal
    $fatal(1, "simplex_resp_xbar: illegal NumIn/NumOut/FifoDepth");
  end

  // FIFO state
  logic [NumOut-1:0][FifoDepth-1:0][NumInLog-1:0]  ini_mem_q, ini_mem_d;
  logic [NumOut-1:0][FifoDepth-1:0][DataWidth-1:0] data_mem_q, data_mem_d;
  logic [NumOut-1:0][PtrW-1:0]                     wr_ptr_q, wr_ptr_d;
  logic [NumOut-1:0][PtrW-1:0]                     rd_ptr_q, rd_ptr_d;
  logic [NumOut-1:0][CntW-1:0]                     cnt_q, cnt_d;
  logic [NumOut-1:0]                               drop_q, drop_d;

  // Arbiter state
  logic [NumIn-1:0][NumOutLog-1:0] rr_ptr_q, rr_ptr_d;
  logic [NumIn-1:0]                lock_q, lock_d;
  logic [NumIn-1:0][NumOutLog-1:0] lock_idx_q, lock_idx_d;

  logic [NumOut-1:0]                fifo_empty, fifo_full;
  logic [NumOut-1:0][NumInLog-1:0]  head_ini;
  logic [NumOut-1:0][DataWidth-1:0] head_data;
  logic [NumIn-1:0][NumOut-1:0]     req;
  logic [NumIn-1:0][NumOutLog-1:0]  gnt_idx;
  logic [NumIn-1:0]                 hs;
  logic [NumOut-1:0]                pop, push, in_range, store;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    for (int k = 0; k < NumOut; k++) begin
      fifo_empty[k] = (cnt_q[k] == '0);
      fifo_full[k]  = (cnt_q[k] == CntW'(FifoDepth));
      head_ini[k]   = ini_mem_q[k][rd_ptr_q[k]];
      head_data[k]  = data_mem_q[k][rd_ptr_q[k]];
    end
  end

  assign resp_ready_o = ~fifo_full;
  assign drop_o       = drop_q;

  // Per-initiator round-robin with grant lock.
  always_comb begin
    int unsigned idx;
    idx             = 0;
    req             = '0;
    gnt_idx         = '0;
    hs              = '0;
    pop             = '0;
    resp_valid_o    = '0;
    resp_tgt_addr_o = '0;
    resp_data_o     = '0;
    rr_ptr_d        = rr_ptr_q;
    lock_d          = lock_q;
    lock_idx_d      = lock_idx_q;
    for (int j = 0; j < NumIn; j++) begin
      for (int k = 0; k < NumOut; k++) begin
        req[j][k] = !fifo_empty[k] && (int'(head_ini[k]) == j);
      end
      if (lock_q[j]) begin
        // The locked head cannot leave its FIFO until this initiator takes it.
        resp_valid_o[j] = 1'b1;
        gnt_idx[j]      = lock_idx_q[j];
      end else begin
        // Scan farthest-to-nearest from rr_ptr so the nearest requester wins.
        for (int o = NumOut - 1; o >= 0; o--) begin
          idx = (int'(rr_ptr_q[j]) + o) % NumOut;
          if (req[j][idx]) begin
            resp_valid_o[j] = 1'b1;
            gnt_idx[j]      = NumOutLog'(idx);
          end
        end
      end
      resp_tgt_addr_o[j] = gnt_idx[j];
      resp_data_o[j]     = head_data[gnt_idx[j]];
      hs[j]              = resp_valid_o[j] && resp_ready_i[j];
      if (hs[j]) begin
        pop[gnt_idx[j]] = 1'b1;
        rr_ptr_d[j]     = NumOutLog'((int'(gnt_idx[j]) + 1) % NumOut);
        lock_d[j]       = 1'b0;
      end else if (resp_valid_o[j]) begin
        lock_d[j]     = 1'b1;
        lock_idx_d[j] = gnt_idx[j];
      end
    end
  end

  // Target FIFOs. A full FIFO refuses the push even when it pops this cycle.
  always_comb begin
    ini_mem_d  = ini_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    drop_d     = '0;
    push       = '0;
    in_range   = '0;
    store      = '0;
    for (int k = 0; k < NumOut; k++) begin
      push[k]     = resp_valid_i[k] && !fifo_full[k];
      in_range[k] = ({1'b0, resp_ini_addr_i[k]} < NumInLimit);
      store[k]    = push[k] && in_range[k];
      drop_d[k]   = push[k] && !in_range[k];
      if (store[k]) begin
        ini_mem_d[k][wr_ptr_q[k]]  = resp_ini_addr_i[k];
        data_mem_d[k][wr_ptr_q[k]] = resp_data_i[k];
        wr_ptr_d[k]                = ptr_inc(wr_ptr_q[k]);
      end
      if (pop[k]) begin
        rd_ptr_d[k] = ptr_inc(rd_ptr_q[k]);
      end
      case ({store[k], pop[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + CntW'(1);
        2'b01:   cnt_d[k] = cnt_q[k] - CntW'(1);
        default: cnt_d[k] = cnt_q[k];
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ini_mem_q  <= '0;
      data_mem_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      drop_q     <= '0;
      rr_ptr_q   <= '0;
      lock_q     <= '0;
      lock_idx_q <= '0;
    end else begin
      ini_mem_q  <= ini_mem_d;
      data_mem_q <= data_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

`ifndef SYNTHESIS
  // A stalled output must hold valid, source index and payload until taken.
  for (genvar j = 0; j < NumIn; j++) begin : g_lock_chk
    a_lock_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (resp_valid_o[j] && !resp_ready_i[j]) |=>
        (resp_valid_o[j] && $stable(resp_tgt_addr_o[j]) && $stable(resp_data_o[j])));
  end
`endif

endmodule

// File: tb/tb_simplex_resp_xbar.sv
module tb_simplex_resp_xbar;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        resp_valid_i;
  logic [3:0]        resp_ready_o;
  logic [3:0][1:0]   resp_ini_addr_i;
  logic [3:0][31:0]  resp_data_i;
  logic [3:0]        resp_valid_o;
  logic [3:0]        resp_ready_i;
  logic [3:0][1:0]   resp_tgt_addr_o;
  logic [3:0][31:0]  resp_data_o;
  logic [3:0]        drop_o;

  // Second instance with a non-power-of-two initiator count.
  logic [3:0]        valid_i3;
  logic [3:0]        ready_o3;
  logic [3:0][1:0]   ini_addr_i3;
  logic [3:0][31:0]  data_i3;
  logic [2:0]        valid_o3;
  logic [2:0]        ready_i3;
  logic [2:0][1:0]   tgt_addr_o3;
  logic [2:0][31:0]  data_o3;
  logic [3:0]        drop_o3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  simplex_resp_xbar u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o),
    .resp_ini_addr_i(resp_ini_addr_i), .resp_data_i(resp_data_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_tgt_addr_o(resp_tgt_addr_o), .resp_data_o(resp_data_o),
    .drop_o(drop_o)
  );

  simplex_resp_xbar #(.NumIn(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .resp_valid_i(valid_i3), .resp_ready_o(ready_o3),
    .resp_ini_addr_i(ini_addr_i3), .resp_data_i(data_i3),
    .resp_valid_o(valid_o3), .resp_ready_i(ready_i3),
    .resp_tgt_addr_o(tgt_addr_o3), .resp_data_o(data_o3),
    .drop_o(drop_o3)
  );

  task automatic idle_inputs();
    resp_valid_i = '0; resp_ini_addr_i = '0; resp_data_i = '0; resp_ready_i = '1;
    valid_i3 = '0; ini_addr_i3 = '0; data_i3 = '0; ready_i3 = '1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid_o !== 4'b0000 || resp_ready_o !== 4'b1111 || drop_o !== 4'b0000) begin
      failures++;
      $display("FAIL reset_idle: valid=%b ready=%b drop=%b expected 0000/1111/0000",
               resp_valid_o, resp_ready_o, drop_o);
    end
    apply_reset();
    // Two entries into FIFO 1, initiator 0 stalled.
    resp_ready_i = 4'b0000;
    resp_valid_i = 4'b0010; resp_ini_addr_i[1] = 2'd0; resp_data_i[1] = 32'h1111_0001;
    @(negedge clk);
    resp_data_i[1] = 32'h1111_0002;
    @(negedge clk);
    resp_valid_i = '0;
    checks++;
    if (resp_valid_o[0] !== 1'b1 || resp_ready_o[1] !== 1'b0) begin
      failures++;
      $display("FAIL reset_fill: valid0=%b ready1=%b expected 1/0", resp_valid_o[0], resp_ready_o[1]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid_o !== 4'b0000 || resp_ready_o !== 4'b1111) begin
      failures++;
      $display("FAIL reset_mid: valid=%b ready=%b expected 0000/1111", resp_valid_o, resp_ready_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    resp_ready_i = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (resp_valid_o !== 4'b0000) begin
        failures++;
        $display("FAIL reset_stale: valid=%b expected 0000", resp_valid_o);
      end
    end
  endtask

  task automatic test_single_path();
    apply_reset();
    resp_valid_i = 4'b0100; resp_ini_addr_i[2] = 2'd3; resp_data_i[2] = 32'hA5A5_0001;
    @(negedge clk);
    resp_valid_i = '0;
    checks++;
    if (resp_valid_o !== 4'b1000 || resp_tgt_addr_o[3] !== 2'd2 || resp_data_o[3] !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL single_path: valid=%b tgt=%0d data=%h expected 1000/2/a5a50001",
               resp_valid_o, resp_tgt_addr_o[3], resp_data_o[3]);
    end
    @(negedge clk);
    checks++;
    if (resp_valid_o !== 4'b0000 || resp_ready_o !== 4'b1111) begin
      failures++;
      $display("FAIL single_drain: valid=%b ready=%b expected 0000/1111", resp_valid_o, resp_ready_o);
    end
  endtask

  task automatic test_rr_fairness();
    int exp_t[3] = '{0, 1, 3};
    apply_reset();
    resp_valid_i = 4'b1011;
    resp_ini_addr_i = '0;
    for (int k = 0; k < 4; k++) resp_data_i[k] = 32'hF000_0000 | k;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (resp_valid_o[0] !== 1'b1 || resp_tgt_addr_o[0] !== 2'(exp_t[i % 3]) ||
          resp_data_o[0] !== (32'hF000_0000 | exp_t[i % 3])) begin
        failures++;
        $display("FAIL rr_order[%0d]: valid=%b tgt=%0d data=%h expected 1/%0d", i,
                 resp_valid_o[0], resp_tgt_addr_o[0], resp_data_o[0], exp_t[i % 3]);
      end
      @(negedge clk);
    end
    resp_valid_i = '0;
  endtask

  task automatic test_lock();
    apply_reset();
    resp_ready_i = 4'b1101;
    resp_valid_i = 4'b0100; resp_ini_addr_i[2] = 2'd1; resp_data_i[2] = 32'hD2D2_0002;
    @(negedge clk);
    resp_valid_i = 4'b0001; resp_ini_addr_i[0] = 2'd1; resp_data_i[0] = 32'hD0D0_0000;
    @(negedge clk);
    resp_valid_i = '0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (resp_valid_o[1] !== 1'b1 || resp_tgt_addr_o[1] !== 2'd2 || resp_data_o[1] !== 32'hD2D2_0002) begin
        failures++;
        $display("FAIL lock_hold: valid=%b tgt=%0d data=%h expected 1/2/d2d20002",
                 resp_valid_o[1], resp_tgt_addr_o[1], resp_data_o[1]);
      end
      @(negedge clk);
    end
    resp_ready_i = 4'b1111;
    @(negedge clk);
    checks++;
    if (resp_valid_o[1] !== 1'b1 || resp_tgt_addr_o[1] !== 2'd0 || resp_data_o[1] !== 32'hD0D0_0000) begin
      failures++;
      $display("FAIL lock_next: valid=%b tgt=%0d data=%h expected 1/0/d0d00000",
               resp_valid_o[1], resp_tgt_addr_o[1], resp_data_o[1]);
    end
    @(negedge clk);
    checks++;
    if (resp_valid_o !== 4'b0000) begin
      failures++;
      $display("FAIL lock_drain: valid=%b expected 0000", resp_valid_o);
    end
  endtask

  task automatic test_full_fifo();
    apply_reset();
    resp_ready_i = 4'b0000;
    resp_valid_i = 4'b0001; resp_ini_addr_i[0] = 2'd0; resp_data_i[0] = 32'hB000_0000;
    @(negedge clk);
    resp_data_i[0] = 32'hB000_0001;
    @(negedge clk);
    resp_data_i[0] = 32'hB000_0002;
    checks++;
    if (resp_ready_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL full_ready: ready0=%b expected 0", resp_ready_o[0]);
    end
    resp_ready_i = 4'b0001;  // pop on full: pushed beat must not enter
    @(negedge clk);
    checks++;
    if (resp_ready_o[0] !== 1'b1 || resp_data_o[0] !== 32'hB000_0001) begin
      failures++;
      $display("FAIL full_pop: ready0=%b data=%h expected 1/b0000001", resp_ready_o[0], resp_data_o[0]);
    end
    @(negedge clk);
    resp_valid_i = '0;
    checks++;
    if (resp_valid_o[0] !== 1'b1 || resp_data_o[0] !== 32'hB000_0002) begin
      failures++;
      $display("FAIL full_third: valid0=%b data=%h expected 1/b0000002", resp_valid_o[0], resp_data_o[0]);
    end
    @(negedge clk);
    checks++;
    if (resp_valid_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL full_dup: valid0=%b expected 0", resp_valid_o[0]);
    end
  endtask

  task automatic test_out_of_range();
    apply_reset();
    valid_i3 = 4'b0010; ini_addr_i3[1] = 2'd3; data_i3[1] = 32'hDEAD_0003;
    checks++;
    if (drop_o3 !== 4'b0000) begin
      failures++;
      $display("FAIL oor_pre: drop=%b expected 0000", drop_o3);
    end
    @(negedge clk);
    valid_i3 = '0;
    checks++;
    if (drop_o3 !== 4'b0010 || valid_o3 !== 3'b000 || ready_o3 !== 4'b1111) begin
      failures++;
      $display("FAIL oor_pulse: drop=%b valid=%b ready=%b expected 0010/000/1111", drop_o3, valid_o3, ready_o3);
    end
    @(negedge clk);
    checks++;
    if (drop_o3 !== 4'b0000 || valid_o3 !== 3'b000) begin
      failures++;
      $display("FAIL oor_end: drop=%b valid=%b expected 0000/000", drop_o3, valid_o3);
    end
    // Count must still be zero: exactly two further pushes fill the FIFO.
    ready_i3 = 3'b000;
    valid_i3 = 4'b0010; ini_addr_i3[1] = 2'd0; data_i3[1] = 32'h3333_0000;
    @(negedge clk);
    checks++;
    if (ready_o3[1] !== 1'b1) begin
      failures++;
      $display("FAIL oor_count1: ready1=%b expected 1", ready_o3[1]);
    end
    @(negedge clk);
    valid_i3 = '0;
    checks++;
    if (ready_o3[1] !== 1'b0 || valid_o3 !== 3'b001 || data_o3[0] !== 32'h3333_0000) begin
      failures++;
      $display("FAIL oor_count2: ready1=%b valid=%b data=%h expected 0/001/33330000",
               ready_o3[1], valid_o3, data_o3[0]);
    end
  endtask

  // Queue-based reference: per-target FIFOs, per-initiator "next after last
  // served" pointer, and a held grant while the initiator stalls.
  task automatic test_random(input int n);
    int unsigned q_ini[4][$];
    logic [31:0] q_dat[4][$];
    int rr[4];
    bit lk[4];
    int lk_t[4];
    apply_reset();
    for (int j = 0; j < 4; j++) begin rr[j] = 0; lk[j] = 0; lk_t[j] = 0; end
    for (int c = 0; c < n; c++) begin
      bit ev[4];
      int eg[4];
      bit full[4];
      for (int j = 0; j < 4; j++) begin
        ev[j] = 0; eg[j] = 0;
        if (lk[j]) begin
          ev[j] = 1; eg[j] = lk_t[j];
        end else begin
          for (int o = 0; o < 4; o++) begin
            int k;
            k = (rr[j] + o) % 4;
            if (!ev[j] && q_ini[k].size() > 0 && q_ini[k][0] == j) begin ev[j] = 1; eg[j] = k; end
          end
        end
        checks++;
        if (resp_valid_o[j] !== ev[j]) begin
          failures++;
          $display("FAIL rnd_valid c%0d i%0d: got %b expected %b", c, j, resp_valid_o[j], ev[j]);
        end else if (ev[j]) begin
          checks++;
          if (resp_tgt_addr_o[j] !== 2'(eg[j]) || resp_data_o[j] !== q_dat[eg[j]][0]) begin
            failures++;
            $display("FAIL rnd_resp c%0d i%0d: tgt=%0d data=%h expected %0d/%h", c, j,
                     resp_tgt_addr_o[j], resp_data_o[j], eg[j], q_dat[eg[j]][0]);
          end
        end
      end
      for (int k = 0; k < 4; k++) begin
        full[k] = (q_ini[k].size() >= 2);
        checks++;
        if (resp_ready_o[k] !== !full[k]) begin
          failures++;
          $display("FAIL rnd_ready c%0d t%0d: got %b expected %b", c, k, resp_ready_o[k], !full[k]);
        end
      end
      checks++;
      if (drop_o !== 4'b0000) begin
        failures++;
        $display("FAIL rnd_drop c%0d: got %b expected 0000", c, drop_o);
      end
      resp_valid_i = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) begin
        resp_ini_addr_i[k] = 2'($urandom_range(0, 3));
        resp_data_i[k] = $urandom;
      end
      for (int j = 0; j < 4; j++) resp_ready_i[j] = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < 4; j++) begin
        if (ev[j] && resp_ready_i[j]) begin
          void'(q_ini[eg[j]].pop_front());
          void'(q_dat[eg[j]].pop_front());
          rr[j] = (eg[j] + 1) % 4;
          lk[j] = 0;
        end else if (ev[j]) begin
          lk[j] = 1; lk_t[j] = eg[j];
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (resp_valid_i[k] && !full[k]) begin
          q_ini[k].push_back(resp_ini_addr_i[k]);
          q_dat[k].push_back(resp_data_i[k]);
        end
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_path();
    test_rr_fairness();
    test_lock();
    test_full_fifo();
    test_out_of_range();
    test_random(400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
